// File: rtl/spi_master_multi_if.sv
// -----------------------------------------------------------------------------
// spi_master_multi_if
// Request/response bundle between the DAQ register logic and the SPI engine.
//
//   tx_data     fully formatted write frame, MSB first from bit DATA_WIDTH-1
//   write_bits  number of bits shifted out
//   read_bits   number of bits sampled after the write phase
//   cs_sel      index of the target chip select
//   mode_3wire  1 = read back on sdio, 0 = read back on miso
//   start       request strobe, only honoured while the engine is idle
//   busy        transaction in progress
//   done        one-cycle completion pulse
//   err         one-cycle pulse, request rejected
//   rx_data     sampled read bits, right-justified
//
// modport master: the requesting side (register logic)
// modport slave : the SPI engine, which serves the requests
// -----------------------------------------------------------------------------
interface spi_master_multi_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6,
    parameter int CS_SEL_W   = 2
) ();
    logic [DATA_WIDTH-1:0] tx_data;
    logic [CNT_WIDTH-1:0]  write_bits;
    logic [CNT_WIDTH-1:0]  read_bits;
    logic [CS_SEL_W-1:0]   cs_sel;
    logic                  mode_3wire;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [DATA_WIDTH-1:0] rx_data;

    modport master (
        output tx_data, write_bits, read_bits, cs_sel, mode_3wire, start,
        input  busy, done, err, rx_data
    );

    modport slave (
        input  tx_data, write_bits, read_bits, cs_sel, mode_3wire, start,
        output busy, done, err, rx_data
    );
endinterface

// File: rtl/spi_master_multi.sv
// -----------------------------------------------------------------------------
// spi_master_multi
// Parametrised SPI master for the on-board ADC/PLL devices. The caller hands
// over a complete frame (R/W bit, address, payload); the engine shifts out
// write_bits bits MSB first, then samples read_bits bits, on one of NUM_CS
// active-low chip selects, in 3-wire (shared sdio) or 4-wire (miso) mode.
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   req    request/response bundle (slave side)
//   sclk   serial clock, idles high, toggles only while shifting
//   sdio   serial data out; released during the 3-wire read phase
//   miso   serial data in for 4-wire operation
//   csb    active-low chip selects, at most one low at a time
//
// Frame timing (C = CLK_DIV): SETUP C cycles, N bit periods of 2C cycles
// (low half then high half), HOLD C cycles, then one FINISH cycle with done.
// -----------------------------------------------------------------------------
module spi_master_multi #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6,
    parameter int NUM_CS     = 4,
    parameter int CS_SEL_W   = 2,
    parameter int CLK_DIV    = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_multi_if.slave req,
    output logic              sclk,
    inout  wire               sdio,
    input  logic              miso,
    output logic [NUM_CS-1:0] csb
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        FINISH
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] tx_sh_q;
    logic [DATA_WIDTH-1:0] rx_sh_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic [CNT_WIDTH-1:0]  wb_q;
    logic [CNT_WIDTH:0]    len_q;
    logic [CNT_WIDTH:0]    bit_q;
    logic [DIV_W-1:0]      div_q;
    logic                  mode_q;
    logic                  sclk_q;
    logic                  sdio_oe_q;
    logic                  sdio_out_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [NUM_CS-1:0]     csb_q;

    logic [NUM_CS-1:0]     cs_onehot;
    logic [CNT_WIDTH:0]    req_len;
    logic                  req_ok;
    logic                  div_end;
    logic                  last_bit;
    logic                  next_is_write;
    logic                  rx_bit;

    // Chip-select decode of the requested device.
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
        assign cs_onehot[gi] = (int'(req.cs_sel) == gi);
    end

    assign req_len = {1'b0, req.write_bits} + {1'b0, req.read_bits};
    assign req_ok  = (req_len != '0)
                  && (int'(req.write_bits) <= DATA_WIDTH)
                  && (int'(req.read_bits)  <= DATA_WIDTH)
                  && (int'(req.cs_sel)     <  NUM_CS);

    assign div_end       = (div_q == DIV_LAST);
    assign last_bit      = (bit_q == len_q - 1'b1);
    // Classification of the bit period that starts at the coming falling edge.
    assign next_is_write = ((bit_q + 1'b1) < {1'b0, wb_q});
    assign rx_bit        = mode_q ? sdio : miso;

    assign sdio        = sdio_oe_q ? sdio_out_q : 1'bz;
    assign sclk        = sclk_q;
    assign csb         = csb_q;
    assign req.busy    = busy_q;
    assign req.done    = done_q;
    assign req.err     = err_q;
    assign req.rx_data = rx_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            wb_q       <= '0;
            len_q      <= '0;
            bit_q      <= '0;
            div_q      <= '0;
            mode_q     <= 1'b0;
            sclk_q     <= 1'b1;
            sdio_oe_q  <= 1'b0;
            sdio_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            csb_q      <= '1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                // FINISH behaves like IDLE for new requests so a queued frame
                // can follow with only the done cycle of csb-high gap.
                IDLE, FINISH: begin
                    state_q <= IDLE;
                    if (req.start) begin
                        if (req_ok) begin
                            state_q <= SETUP;
                            busy_q  <= 1'b1;
                            csb_q   <= ~cs_onehot;
                            tx_sh_q <= req.tx_data;
                            wb_q    <= req.write_bits;
                            len_q   <= req_len;
                            mode_q  <= req.mode_3wire;
                            div_q   <= '0;
                            bit_q   <= '0;
                            rx_sh_q <= '0;
                            if (req.write_bits != '0) begin
                                sdio_oe_q  <= 1'b1;
                                sdio_out_q <= req.tx_data[DATA_WIDTH-1];
                            end else begin
                                // Read-only frame: read-phase drive from the start.
                                sdio_oe_q  <= ~req.mode_3wire;
                                sdio_out_q <= 1'b0;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                SETUP: begin
                    div_q <= div_q + 1'b1;
                    if (div_end) begin
                        // First falling edge; bit 0 is already on sdio.
                        div_q   <= '0;
                        sclk_q  <= 1'b0;
                        state_q <= SHIFT;
                    end
                end

                SHIFT: begin
                    div_q <= div_q + 1'b1;
                    if (div_end) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            // Rising edge: capture read-phase bits.
                            sclk_q <= 1'b1;
                            if (bit_q >= {1'b0, wb_q}) begin
                                rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], rx_bit};
                            end
                        end else if (last_bit) begin
                            state_q <= HOLD;
                        end else begin
                            // Falling edge: start the next bit period.
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + 1'b1;
                            if (next_is_write) begin
                                sdio_oe_q  <= 1'b1;
                                sdio_out_q <= tx_sh_q[DATA_WIDTH-2];
                                tx_sh_q    <= {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                            end else begin
                                sdio_oe_q  <= ~mode_q;
                                sdio_out_q <= 1'b0;
                            end
                        end
                    end
                end

                HOLD: begin
                    div_q <= div_q + 1'b1;
                    if (div_end) begin
                        div_q     <= '0;
                        state_q   <= FINISH;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        csb_q     <= '1;
                        sdio_oe_q <= 1'b0;
                        rx_data_q <= rx_sh_q;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
